// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared encodings for the byte-serial memory arbiter.
//   - FSM state encoding, transfer owner encoding
//   - mem_len codes (byte count minus one)
//   - reset / chip-enable active levels
package mem_arbiter_pkg;

  localparam logic RstEnable  = 1'b1;
  localparam logic ChipEnable = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_IF_RD  = 3'd1,
    ST_MEM_RD = 3'd2,
    ST_MEM_WR = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_e;

  localparam logic [1:0] MEM_LEN_BYTE = 2'd0;
  localparam logic [1:0] MEM_LEN_HALF = 2'd1;
  localparam logic [1:0] MEM_LEN_WORD = 2'd3;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of request/response and RAM-side signals.
//   slave  : arbiter view (requests + ram_din in, RAM drive + results out)
//   master : environment view (pipeline stages and RAM model)
interface mem_arbiter_if #(parameter int ADDR_W = 32);
  // instruction fetch
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_abort;
  logic [31:0]       if_data;
  logic              if_done;
  logic              if_busy;
  // data access
  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_len;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_done;
  logic              stall_req;
  // byte-wide RAM port
  logic [7:0]        ram_din;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_dout;
  logic              ram_wr;

  modport slave (
    input  if_req, if_addr, if_abort, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
    output if_data, if_done, if_busy, mem_rdata, mem_done, stall_req, ram_addr, ram_dout, ram_wr
  );

  modport master (
    output if_req, if_addr, if_abort, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
    input  if_data, if_done, if_busy, mem_rdata, mem_done, stall_req, ram_addr, ram_dout, ram_wr
  );
endinterface

// File: rtl/mem_byte_serdes.sv
// mem_byte_serdes: serialises one 1..4 byte transfer, little-endian.
//   start_i          : latch base/len/we/wdata, clear cnt and assembly word
//   en_i             : advance one byte step (cnt+1), capturing read bytes
//   addr_o           : base+cnt (wraps modulo 2^ADDR_W)
//   byte_o           : write byte cnt of the latched word
//   word_o           : assembly word including this cycle's capture
//   last_o           : current step is the final one of the transfer
module mem_byte_serdes
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [1:0]        len_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [31:0]       wdata_i,
  input  logic [7:0]        ram_din_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [7:0]        byte_o,
  output logic [31:0]       word_o,
  output logic              last_o
);

  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        n_q, n_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [31:0]       word_q, word_d;
  logic [1:0]        lane;

  // Read data lags its address by one cycle, so the byte on ram_din
  // belongs to lane cnt-1.
  assign lane = cnt_q[1:0] - 2'd1;

  always_comb begin
    cnt_d   = cnt_q;
    n_d     = n_q;
    base_d  = base_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    word_d  = word_q;
    if (start_i) begin
      cnt_d   = 3'd0;
      n_d     = {1'b0, len_i} + 3'd1;
      base_d  = base_i;
      wdata_d = wdata_i;
      we_d    = we_i;
      word_d  = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 3'd1;
      if (!we_q && cnt_q != 3'd0)
        word_d[{lane, 3'b000} +: 8] = ram_din_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      cnt_q   <= 3'd0;
      n_q     <= 3'd0;
      base_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      word_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      word_q  <= word_d;
    end
  end

  // Writes finish on byte N-1; reads need one extra step to catch the
  // trailing byte.
  assign last_o = we_q ? (cnt_q == n_q - 3'd1) : (cnt_q == n_q);
  assign addr_o = base_q + ADDR_W'(cnt_q);
  assign byte_o = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
  assign word_o = word_d;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide RAM port between instruction fetch and
// the MEM stage.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mem_arbiter_if.slave (requests, results, RAM port, if_busy,
//              stall_req)
// Parameters: ADDR_W address width, MEM_PRIO (1 = MEM wins a tie in IDLE).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int MEM_PRIO = 1
) (
  input  logic clk,
  input  logic rst,
  mem_arbiter_if.slave bus
);

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;

  logic              if_ok, pick_mem, pick_if, start, en, sd_we;
  logic [1:0]        sd_len;
  logic [ADDR_W-1:0] sd_base, sd_addr;
  logic [7:0]        sd_byte;
  logic [31:0]       sd_word;
  logic              sd_last;

  // Grant decision, only consumed in IDLE. An abort in the same cycle as
  // if_req suppresses the fetch so a stale PC is never fetched.
  always_comb begin
    if_ok    = bus.if_req & ~bus.if_abort;
    pick_mem = bus.mem_req & ((MEM_PRIO != 0) | ~if_ok);
    pick_if  = if_ok & ~pick_mem;
    start    = (state_q == ST_IDLE) & (pick_mem | pick_if);
    sd_len   = pick_mem ? bus.mem_len  : MEM_LEN_WORD;
    sd_base  = pick_mem ? bus.mem_addr : bus.if_addr;
    sd_we    = pick_mem & bus.mem_we;
  end

  mem_byte_serdes #(.ADDR_W(ADDR_W)) u_serdes (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start),
    .en_i      (en),
    .we_i      (sd_we),
    .len_i     (sd_len),
    .base_i    (sd_base),
    .wdata_i   (bus.mem_wdata),
    .ram_din_i (bus.ram_din),
    .addr_o    (sd_addr),
    .byte_o    (sd_byte),
    .word_o    (sd_word),
    .last_o    (sd_last)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // Next state; result words are loaded on the edge into DONE so they are
  // already valid while done is high.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_mem) begin
          owner_d = OWN_MEM;
          state_d = bus.mem_we ? ST_MEM_WR : ST_MEM_RD;
        end else if (pick_if) begin
          owner_d = OWN_IF;
          state_d = ST_IF_RD;
        end
      end
      ST_IF_RD: begin
        if (bus.if_abort) begin
          state_d = ST_IDLE;
        end else if (sd_last) begin
          state_d   = ST_DONE;
          if_data_d = sd_word;
        end
      end
      ST_MEM_RD: begin
        if (sd_last) begin
          state_d     = ST_DONE;
          mem_rdata_d = sd_word;
        end
      end
      ST_MEM_WR: if (sd_last) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    en            = 1'b0;
    bus.if_busy   = 1'b0;
    bus.ram_wr    = ~ChipEnable;
    bus.ram_addr  = '0;
    bus.ram_dout  = 8'h00;
    bus.if_done   = 1'b0;
    bus.mem_done  = 1'b0;
    case (state_q)
      ST_IF_RD: begin
        en           = 1'b1;
        bus.if_busy  = 1'b1;
        bus.ram_addr = sd_addr;
      end
      ST_MEM_RD: begin
        en           = 1'b1;
        bus.ram_addr = sd_addr;
      end
      ST_MEM_WR: begin
        en           = 1'b1;
        bus.ram_wr   = ChipEnable;
        bus.ram_addr = sd_addr;
        bus.ram_dout = sd_byte;
      end
      ST_DONE: begin
        bus.if_done  = (owner_q == OWN_IF);
        bus.mem_done = (owner_q == OWN_MEM);
      end
      default: ;
    endcase
    bus.if_data   = if_data_q;
    bus.mem_rdata = mem_rdata_q;
    // Released in the DONE cycle so the MEM stage can advance with the data.
    bus.stall_req = bus.mem_req & ~((state_q == ST_DONE) & (owner_q == OWN_MEM));
  end

endmodule
